// File: rtl/npc_ctrl_pkg.sv
// Shared types for the NPC core sequencer: state encoding and fault causes.
package npc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_FETCH,
    ST_IWAIT,
    ST_EXEC,
    ST_MEM,
    ST_MWAIT,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_IFU_ERR  = 3'd1;
  localparam logic [2:0] FC_LSU_ERR  = 3'd2;
  localparam logic [2:0] FC_TIMEOUT  = 3'd3;
  localparam logic [2:0] FC_MISALIGN = 3'd4;

  // States whose residency is bounded by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_IWAIT) || (s == ST_MEM) || (s == ST_MWAIT);
  endfunction

endpackage

// File: rtl/npc_watchdog.sv
// Residency watchdog: counts cycles spent in a wait state, flags the last allowed one.
module npc_watchdog #(
  parameter int unsigned WDOG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // cnt_q holds the number of cycles already completed in the state, so the
  // (2**WDOG_W-1)-th cycle is the one where cnt_q equals 2**WDOG_W-2.
  localparam logic [WDOG_W-1:0] LAST = ~(WDOG_W'(1));

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/npc_core_ctrl.sv
// Multi-cycle NPC core sequencer: owns the PC, handshakes with IFU/LSU, retires instructions.
module npc_core_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned        XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h8000_0000,
  parameter int unsigned        WDOG_W   = 8,
  parameter int unsigned        CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst,
  input  logic             dec_mem_ren,
  input  logic             dec_mem_wen,
  input  logic             dec_halt,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  input  logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  pc,
  output logic             wb_en,
  output logic             commit,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       fault_cause
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [2:0]       cause_q, cause_d;

  logic wdog_clr;
  logic wdog_en;
  logic wdog_expired;

  npc_watchdog #(
    .WDOG_W(WDOG_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expired(wdog_expired)
  );

  // Clear on entry so the first cycle of every wait state starts from zero.
  assign wdog_en  = is_wait_state(state_q);
  assign wdog_clr = is_wait_state(state_d) && (state_d != state_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    retired_d     = retired_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    wb_en         = 1'b0;
    commit        = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        ifu_req_valid = 1'b1;
        if (wdog_expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end else if (ifu_req_ready) begin
          state_d = ST_IWAIT;
        end
      end

      ST_IWAIT: begin
        if (wdog_expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end else if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = FC_IFU_ERR;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (dec_halt) begin
          commit    = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          halted_d  = 1'b1;
          state_d   = ST_HALT;
        end else if (dec_mem_ren || dec_mem_wen) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        lsu_req_valid = 1'b1;
        if (wdog_expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end else if (lsu_req_ready) begin
          state_d = ST_MWAIT;
        end
      end

      ST_MWAIT: begin
        if (wdog_expired) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end else if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = FC_LSU_ERR;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        if (npc[1:0] != 2'b00) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          cause_d = FC_MISALIGN;
        end else begin
          wb_en     = 1'b1;
          commit    = 1'b1;
          pc_d      = npc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end
      end

      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= FC_NONE;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  assign pc          = pc_q;
  assign inst        = inst_q;
  assign retired     = retired_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_npc_core_ctrl.sv
// Randomized bench for npc_core_ctrl: plays IFU/LSU/IDU and predicts per-instruction timing.
module tb_npc_core_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WDOG_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_HALT = 3, K_IERR = 4,
                 K_LERR = 5, K_TMO = 6, K_RST = 7, K_MIS = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0]      ifu_rsp_inst, inst;
  logic             dec_mem_ren, dec_mem_wen, dec_halt;
  logic             lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [XLEN-1:0]  npc, pc;
  logic             wb_en, commit, halted, fault;
  logic [CNT_W-1:0] retired;
  logic [2:0]       fault_cause;

  always #5 clk = ~clk;

  npc_core_ctrl #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC),
    .WDOG_W  (WDOG_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_err  (ifu_rsp_err),
    .ifu_rsp_inst (ifu_rsp_inst),
    .inst         (inst),
    .dec_mem_ren  (dec_mem_ren),
    .dec_mem_wen  (dec_mem_wen),
    .dec_halt     (dec_halt),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err  (lsu_rsp_err),
    .npc          (npc),
    .pc           (pc),
    .wb_en        (wb_en),
    .commit       (commit),
    .retired      (retired),
    .halted       (halted),
    .fault        (fault),
    .fault_cause  (fault_cause)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          ncyc = 0;
  int          ncyc0 = 0;
  int          commit_at = -1;

  // Architectural reference state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  int unsigned m_ret;
  logic        m_halted;
  logic        m_fault;
  logic [2:0]  m_cause;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  // Everything not explicitly controlled by a phase is noise the DUT must ignore.
  task automatic drive_rand();
    ifu_req_ready = 1'($urandom);
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_err   = 1'($urandom);
    ifu_rsp_inst  = $urandom;
    dec_mem_ren   = 1'($urandom);
    dec_mem_wen   = 1'($urandom);
    dec_halt      = 1'($urandom);
    lsu_req_ready = 1'($urandom);
    lsu_rsp_valid = 1'($urandom);
    lsu_rsp_err   = 1'($urandom);
    npc           = $urandom;
  endtask

  task automatic check_status();
    expect_eq("pc", 64'(pc), 64'(m_pc));
    expect_eq("inst", 64'(inst), 64'(m_inst));
    expect_eq("retired", 64'(retired), 64'(m_ret % (32'd1 << CNT_W)));
    expect_eq("halted", 64'(halted), 64'(m_halted));
    expect_eq("fault", 64'(fault), 64'(m_fault));
    expect_eq("fault_cause", 64'(fault_cause), 64'(m_cause));
  endtask

  task automatic absorb();
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      #1;
      expect_eq("absorb_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
      expect_eq("absorb_strobe", 64'({commit, wb_en}), 64'(0));
      check_status();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_pc = RST_PC; m_inst = '0; m_ret = 0;
    m_halted = 1'b0; m_fault = 1'b0; m_cause = 3'd0;
    expect_eq("rst_outputs", 64'({ifu_req_valid, lsu_req_valid, commit, wb_en}), 64'(0));
    check_status();
    tick();
    rst = 1'b0;
    ncyc0 = ncyc;
    tick();
  endtask

  // Starts at the negedge of the first FETCH cycle of an instruction.
  task automatic do_instr(input int kind, input int dr, input int lr, input int mr,
                          input int ml, input logic [31:0] nv, output bit term);
    logic [31:0] iv;
    bit          is_mem;
    bit          ok;
    iv        = $urandom;
    term      = 1'b1;
    commit_at = -1;
    is_mem    = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_LERR) || (kind == K_RST);

    for (int i = 0; i <= dr; i++) begin
      drive_rand();
      ifu_req_ready = (i == dr);
      #1;
      expect_eq("fetch_valid", 64'(ifu_req_valid), 64'(1));
      expect_eq("fetch_lsu_idle", 64'(lsu_req_valid), 64'(0));
      expect_eq("fetch_strobe", 64'({commit, wb_en}), 64'(0));
      check_status();
      tick();
    end

    if (kind == K_TMO) begin
      for (int k = 0; k < 15; k++) begin
        drive_rand();
        ifu_rsp_valid = 1'b0;
        #1;
        expect_eq("tmo_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
        check_status();
        tick();
      end
      m_fault = 1'b1;
      m_cause = 3'd3;
      drive_rand();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_err   = 1'b0;
      #1;
      check_status();
      tick();
      absorb();
      return;
    end

    for (int j = 1; j <= lr; j++) begin
      drive_rand();
      ifu_rsp_valid = (j == lr);
      ifu_rsp_err   = (j == lr) && (kind == K_IERR);
      if (j == lr) ifu_rsp_inst = iv;
      #1;
      expect_eq("iwait_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
      expect_eq("iwait_strobe", 64'({commit, wb_en}), 64'(0));
      check_status();
      tick();
    end

    if (kind == K_IERR) begin
      m_fault = 1'b1;
      m_cause = 3'd1;
      absorb();
      return;
    end
    m_inst = iv;

    drive_rand();
    dec_halt    = (kind == K_HALT);
    dec_mem_ren = (kind == K_LOAD) || (kind == K_RST) || ((kind == K_HALT) && 1'($urandom));
    dec_mem_wen = (kind == K_STORE) || (kind == K_LERR) || ((kind == K_HALT) && 1'($urandom));
    npc         = nv;
    #1;
    expect_eq("exec_commit", 64'(commit), 64'(kind == K_HALT));
    expect_eq("exec_wb_en", 64'(wb_en), 64'(0));
    expect_eq("exec_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
    check_status();
    if (commit) commit_at = ncyc - ncyc0;
    tick();

    if (kind == K_HALT) begin
      m_ret++;
      m_halted = 1'b1;
      absorb();
      return;
    end

    if (is_mem) begin
      for (int i = 0; i <= mr; i++) begin
        drive_rand();
        lsu_req_ready = (i == mr);
        #1;
        expect_eq("mem_valid", 64'(lsu_req_valid), 64'(1));
        expect_eq("mem_ifu_idle", 64'(ifu_req_valid), 64'(0));
        expect_eq("mem_strobe", 64'({commit, wb_en}), 64'(0));
        check_status();
        tick();
      end
      for (int j = 1; j <= ml; j++) begin
        drive_rand();
        lsu_rsp_valid = (j == ml);
        lsu_rsp_err   = (j == ml) && (kind == K_LERR);
        #1;
        expect_eq("mwait_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
        expect_eq("mwait_strobe", 64'({commit, wb_en}), 64'(0));
        check_status();
        if (kind == K_RST) begin
          do_reset();
          return;
        end
        tick();
      end
      if (kind == K_LERR) begin
        m_fault = 1'b1;
        m_cause = 3'd2;
        absorb();
        return;
      end
    end

    drive_rand();
    npc = nv;
    ok  = (nv[1:0] == 2'b00);
    #1;
    expect_eq("wb_commit", 64'(commit), 64'(ok));
    expect_eq("wb_wb_en", 64'(wb_en), 64'(ok));
    expect_eq("wb_req", 64'({ifu_req_valid, lsu_req_valid}), 64'(0));
    check_status();
    if (commit) commit_at = ncyc - ncyc0;
    tick();

    if (!ok) begin
      m_fault = 1'b1;
      m_cause = 3'd4;
      absorb();
      return;
    end
    m_pc = nv;
    m_ret++;
    term = 1'b0;
  endtask

  function automatic logic [31:0] rand_aligned();
    logic [31:0] r;
    r = $urandom;
    return {r[31:2], 2'b00};
  endfunction

  initial begin
    bit          t;
    int          r;
    int          kind;
    logic [31:0] nv;
    logic [31:0] lo;

    drive_rand();
    #2;
    do_reset();

    // addi then ebreak with zero-wait handshakes
    do_instr(K_ALU, 0, 1, 0, 0, RST_PC + 32'd4, t);
    expect_eq("commit_cycle_addi", 64'(commit_at), 64'(4));
    do_instr(K_HALT, 0, 1, 0, 0, rand_aligned(), t);
    expect_eq("commit_cycle_ebreak", 64'(commit_at), 64'(7));
    expect_eq("halt_pc", 64'(pc), 64'(32'h8000_0004));
    expect_eq("halt_retired", 64'(retired), 64'(2));

    // load with response 3 cycles after acceptance, then stalled fetch, then store error
    do_reset();
    do_instr(K_LOAD, 0, 1, 0, 3, m_pc + 32'd4, t);
    expect_eq("commit_cycle_load", 64'(commit_at), 64'(8));
    do_instr(K_ALU, 5, 1, 0, 0, m_pc + 32'd4, t);
    do_instr(K_LERR, 0, 1, 1, 2, m_pc + 32'd4, t);

    do_reset();
    do_instr(K_TMO, 0, 1, 0, 0, rand_aligned(), t);

    do_reset();
    do_instr(K_ALU, 0, 2, 0, 0, rand_aligned(), t);
    do_instr(K_RST, 1, 1, 0, 2, rand_aligned(), t);
    do_instr(K_MIS, 0, 1, 0, 0, RST_PC + 32'd2, t);

    // retired counter wrap
    do_reset();
    for (int n = 0; n < 18; n++) begin
      do_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 3),
               $urandom_range(0, 3), $urandom_range(1, 4), rand_aligned(), t);
    end
    expect_eq("retired_wrap", 64'(retired), 64'(2));

    do_reset();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 45) kind = K_ALU;
      else if (r < 65) kind = K_LOAD;
      else if (r < 82) kind = K_STORE;
      else if (r < 86) kind = K_HALT;
      else if (r < 89) kind = K_IERR;
      else if (r < 92) kind = K_LERR;
      else if (r < 94) kind = K_TMO;
      else if (r < 97) kind = K_RST;
      else             kind = K_MIS;
      nv = rand_aligned();
      if (kind == K_MIS) begin
        lo = 32'($urandom_range(1, 3));
        nv = nv | lo;
      end
      do_instr(kind, $urandom_range(0, 3), $urandom_range(1, 3),
               $urandom_range(0, 3), $urandom_range(1, 4), nv, t);
      if (t && (kind != K_RST)) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
